alu_md_unit: RTL and testbench

Parametrised successor to the single-cycle ALU control path in the MIPS core. It decodes `ALUop`/`Fun` into an internal operation code and executes single-cycle arithmetic/logic combinationally. It also runs MULT/MULTU/DIV/DIVU on an iterative engine that writes the HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. The block sits in the EX stage and raises `stall` so the controller holds the pipeline while the engine is busy.

---
 rtl/alu_md_pkg.sv | 71 +++++++
 rtl/alu_md_iter.sv | 97 +++++++++
 rtl/alu_md_unit.sv | 80 ++++++++
 tb/tb_alu_md_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared decode types, funct codes and engine state for alu_md_unit.
// Contents: funct localparams, alu_op_e operation enum, dec_t decode record
// (operation, signed flag for MUL/DIV, overflow enable), md_state_e engine states,
// and decode(), which maps ALUop/Fun onto a dec_t.
package alu_md_pkg;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MUL, OP_DIV, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_NOP
    } alu_op_e;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} md_state_e;

    typedef struct packed {
        alu_op_e op;
        logic    sgn;
        logic    ovf;
    } dec_t;

    function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] fun);
        dec_t d;
        d = '{OP_NOP, 1'b0, 1'b0};
        case (alu_op)
            2'b00: d = '{OP_ADD, 1'b0, 1'b1};
            2'b01: d = '{OP_SUB, 1'b0, 1'b1};
            2'b11: d.op = OP_SLT;
            default: case (fun)
                F_ADD:   d = '{OP_ADD, 1'b0, 1'b1};
                F_ADDU:  d.op = OP_ADD;
                F_SUB:   d = '{OP_SUB, 1'b0, 1'b1};
                F_SUBU:  d.op = OP_SUB;
                F_AND:   d.op = OP_AND;
                F_OR:    d.op = OP_OR;
                F_XOR:   d.op = OP_XOR;
                F_NOR:   d.op = OP_NOR;
                F_SLT:   d.op = OP_SLT;
                F_SLTU:  d.op = OP_SLTU;
                F_MULT:  d = '{OP_MUL, 1'b1, 1'b0};
                F_MULTU: d.op = OP_MUL;
                F_DIV:   d = '{OP_DIV, 1'b1, 1'b0};
                F_DIVU:  d.op = OP_DIV;
                F_MFHI:  d.op = OP_MFHI;
                F_MFLO:  d.op = OP_MFLO;
                F_MTHI:  d.op = OP_MTHI;
                F_MTLO:  d.op = OP_MTLO;
                default: ;
            endcase
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter: iterative multiply/divide engine owning the HI/LO registers.
// Ports: clk, rst (async, active high); start/is_div/sgn/a/b launch an operation
// from IDLE; wr_hi/wr_lo/wdata load HI/LO directly while idle; busy while not IDLE;
// done pulses for one cycle when HI/LO take a new mul/div result; hi/lo registers.
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opd, quo, rem;
    logic               div_q, neg_q, neg_r, dz_q, ge;
    logic [WIDTH:0]     sum, shl;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_nx;

    // CALC exits on the same edge that takes the counter from 1 to 0.
    always_comb
        state_nx = state == S_IDLE ? (start ? S_CALC : S_IDLE) :
                   state == S_CALC ? (cnt == CW'(1) ? S_FIX : S_CALC) : S_IDLE;

    always_comb busy = state != S_IDLE;

    // acc_hi:acc_lo is the running product (mul) or remainder:dividend-with-quotient (div).
    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        shl  = {acc_hi, acc_lo[WIDTH-1]};
        ge   = shl >= {1'b0, opd};
        prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo  = dz_q ? {WIDTH{1'b1}} : neg_q ? -acc_lo : acc_lo;
        rem  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opd    <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= state == S_FIX;
            if (state == S_IDLE && start) begin
                cnt    <= CW'(WIDTH);
                acc_hi <= '0;
                acc_lo <= sgn && a[WIDTH-1] ? -a : a;
                opd    <= sgn && b[WIDTH-1] ? -b : b;
                div_q  <= is_div;
                neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= sgn && a[WIDTH-1];
                dz_q   <= is_div && b == '0;
            end else if (state == S_CALC) begin
                cnt <= cnt - CW'(1);
                if (div_q) begin
                    acc_hi <= ge ? WIDTH'(shl - {1'b0, opd}) : shl[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], ge};
                end else begin
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                end
            end else if (state == S_FIX) begin
                hi <= div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo <= div_q ? quo : prod[WIDTH-1:0];
            end
            if (state == S_IDLE && wr_hi) hi <= wdata;
            if (state == S_IDLE && wr_lo) lo <= wdata;
        end

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: EX-stage ALU with iterative multiply/divide and HI/LO moves.
// Ports: clk, rst (async, active high); ALUop/Fun select the operation; issue marks
// a valid EX instruction; a/b operands. result/zero/overflow are combinational;
// busy/done/hi/lo come from the engine; stall holds the pipeline around mul/div.
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       Fun,
    input  logic             issue,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    dec_t             dec;
    logic             md, cls, start, wr_hi, wr_lo;
    logic [WIDTH-1:0] sum, diff;

    // Starting is blocked in the done cycle so a held mul/div retires without relaunching;
    // the start cycle itself stalls so the issuing instruction waits for its result.
    always_comb begin
        dec   = decode(ALUop, Fun);
        md    = dec.op == OP_MUL || dec.op == OP_DIV;
        cls   = md || dec.op inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
        start = issue && md && !busy && !done;
        stall = issue && cls && (busy || start);
        wr_hi = issue && dec.op == OP_MTHI && !busy;
        wr_lo = issue && dec.op == OP_MTLO && !busy;
        sum   = a + b;
        diff  = a - b;
        result = '0;
        case (dec.op)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: ;
        endcase
        zero     = result == '0;
        overflow = dec.ovf && (dec.op == OP_ADD ?
                   a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1] :
                   dec.op == OP_SUB && a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]);
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (dec.op == OP_DIV),
        .sgn    (dec.sgn),
        .a      (a),
        .b      (b),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (a),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: directed self-checking bench for alu_md_unit at WIDTH=32.
module tb_alu_md_unit;

    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1, issue = 1'b0;
    logic [1:0]   ALUop = 2'b00;
    logic [5:0]   Fun = 6'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] result, hi, lo;
    logic         zero, overflow, busy, done, stall;
    int           passed = 0, total = 0;

    always #5 clk = ~clk;

    alu_md_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ALUop(ALUop), .Fun(Fun), .issue(issue),
        .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_chk(input string tag, input logic [1:0] op, input logic [5:0] f,
                           input logic [W-1:0] x, y, input logic [W-1:0] res, input logic ovf);
        ALUop = op; Fun = f; a = x; b = y;
        #1;
        chk(tag, {overflow, zero, result}, {ovf, res == 0, res});
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] x, y,
                          input logic [W-1:0] eh, el);
        int n;
        ALUop = 2'b10; Fun = f; a = x; b = y; issue = 1'b1;
        #1;
        chk({tag, " stall at start"}, stall, 1'b1);
        step;
        chk({tag, " busy"}, {busy, done}, 2'b10);
        n = 0;
        while (!done && n < 40) begin
            step;
            n++;
        end
        chk({tag, " latency"}, n, 33);
        chk({tag, " hi/lo"}, {hi, lo}, {eh, el});
        chk({tag, " stall released"}, {stall, busy}, 2'b00);
        step;
        chk({tag, " done pulse ends, no restart"}, {done, busy}, 2'b00);
        issue = 1'b0;
    endtask

    initial begin
        int  n;
        logic ok;
        #1;
        chk("reset state", {busy, done, stall, hi, lo}, '0);
        repeat (2) step;
        rst = 1'b0;
        #1;
        chk("after reset", {busy, done, stall, hi, lo}, '0);

        alu_chk("add ovf",  2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1);
        alu_chk("addu",     2'b10, 6'b100001, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0);
        alu_chk("sub ovf",  2'b10, 6'b100010, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1);
        alu_chk("subu",     2'b10, 6'b100011, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0);
        alu_chk("and",      2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        alu_chk("or",       2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        alu_chk("xor",      2'b10, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        alu_chk("nor",      2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0);
        alu_chk("slt",      2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        alu_chk("sltu",     2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        alu_chk("slti",     2'b11, 6'b000000, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        alu_chk("addi",     2'b00, 6'b000000, 32'h5, 32'h3, 32'h8, 1'b0);
        alu_chk("addi ovf", 2'b00, 6'b000000, 32'h80000000, 32'h80000000, 32'h0, 1'b1);
        alu_chk("subi zero",2'b01, 6'b000000, 32'h3, 32'h3, 32'h0, 1'b0);
        alu_chk("nop",      2'b10, 6'b000000, 32'h12, 32'h34, 32'h0, 1'b0);

        run_md("mult",  6'b011000, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_md("multu", 6'b011001, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
        alu_chk("mfhi", 2'b10, 6'b010000, 32'h0, 32'h0, 32'h00000002, 1'b0);
        alu_chk("mflo", 2'b10, 6'b010010, 32'h0, 32'h0, 32'hFFFFFFFA, 1'b0);

        ALUop = 2'b10; Fun = 6'b010001; a = 32'h12345678; issue = 1'b1;
        #1;
        chk("mthi no stall", stall, 1'b0);
        step;
        Fun = 6'b010011; a = 32'hCAFEF00D;
        step;
        issue = 1'b0;
        chk("mthi/mtlo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});

        run_md("div",      6'b011010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div neg divisor", 6'b011010, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_md("divu",     6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("divu by0", 6'b011011, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF);

        ALUop = 2'b10; Fun = 6'b011000; a = 32'h10000; b = 32'h10001; issue = 1'b1;
        step;
        chk("mult2 busy", busy, 1'b1);
        Fun = 6'b100000; a = 32'h2; b = 32'h3;
        #1;
        chk("add during busy", {stall, result}, {1'b0, 32'h5});
        repeat (4) step;
        Fun = 6'b010010;
        n = 4;
        ok = 1'b1;
        #1;
        while (!done && n < 40) begin
            if (!stall) ok = 1'b0;
            step;
            n++;
        end
        chk("mflo stalled while busy", ok, 1'b1);
        chk("mflo wait latency", n, 33);
        chk("mflo released", {stall, result, hi}, {1'b0, 32'h00010000, 32'h1});
        issue = 1'b0;
        step;

        ALUop = 2'b10; Fun = 6'b011010; a = 32'd100; b = 32'd7; issue = 1'b1;
        step;
        repeat (10) step;
        chk("div running", busy, 1'b1);
        #2;
        rst = 1'b1;
        issue = 1'b0;
        #1;
        chk("async abort", {busy, done, hi, lo}, '0);
        step;
        rst = 1'b0;
        step;
        chk("no done after abort", {done, busy}, 2'b00);
        run_md("mult 6x7", 6'b011000, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
